// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronises and debounces the up/down buttons,
// runs a tick-driven direction FSM with hold-to-accelerate, and clamps to the playfield.
module paddle_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 64,
  parameter int Y_W         = 10,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 10,
  parameter int DEB_TICKS   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           center,
  output logic [Y_W-1:0] paddle_y,
  output logic           moving,
  output logic           at_top,
  output logic           at_bottom
);
  localparam int YMAX   = SCREEN_H - PADDLE_H;
  localparam int CENTER = YMAX / 2;
  localparam int SPD_W  = $clog2(STEP_MAX + 1);
  localparam int CNT_W  = $clog2(ACCEL_TICKS + 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [Y_W:0]     ye_t;
  typedef logic [SPD_W-1:0] spd_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [DEB_TICKS-1:0] sh_t;

  logic [1:0] up_s_q, dn_s_q;
  sh_t        up_sh_q, up_sh_d, dn_sh_q, dn_sh_d;
  logic       up_st_q, up_st_d, dn_st_q, dn_st_d;
  state_t     state_q, state_d, req;
  spd_t       spd_q, spd_d, spd_cur;
  cnt_t       cnt_q, cnt_d, cnt_cur;
  y_t         y_q, y_d;
  ye_t        y_ext, spd_ext, nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_s_q  <= '0;
      dn_s_q  <= '0;
      up_sh_q <= '0;
      dn_sh_q <= '0;
      up_st_q <= 1'b0;
      dn_st_q <= 1'b0;
      state_q <= IDLE;
      spd_q   <= spd_t'(STEP_MIN);
      cnt_q   <= '0;
      y_q     <= y_t'(CENTER);
    end else begin
      up_s_q  <= {up_s_q[0], btn_up};
      dn_s_q  <= {dn_s_q[0], btn_down};
      up_sh_q <= up_sh_d;
      dn_sh_q <= dn_sh_d;
      up_st_q <= up_st_d;
      dn_st_q <= dn_st_d;
      state_q <= state_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  // Stable level only flips once the whole sample window agrees.
  always_comb begin
    up_sh_d = up_sh_q;
    dn_sh_d = dn_sh_q;
    up_st_d = up_st_q;
    dn_st_d = dn_st_q;
    if (tick) begin
      up_sh_d = (up_sh_q << 1) | sh_t'(up_s_q[1]);
      dn_sh_d = (dn_sh_q << 1) | sh_t'(dn_s_q[1]);
      if (&up_sh_d)       up_st_d = 1'b1;
      else if (~|up_sh_d) up_st_d = 1'b0;
      if (&dn_sh_d)       dn_st_d = 1'b1;
      else if (~|dn_sh_d) dn_st_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    spd_cur = spd_q;
    cnt_cur = cnt_q;
    nxt     = '0;
    req     = IDLE;
    if (up_st_q && !dn_st_q)      req = UP;
    else if (dn_st_q && !up_st_q) req = DOWN;
    y_ext   = ye_t'(y_q);
    spd_ext = '0;
    if (center) begin
      state_d = IDLE;
      spd_d   = spd_t'(STEP_MIN);
      cnt_d   = '0;
      y_d     = y_t'(CENTER);
    end else if (tick) begin
      state_d = req;
      // A direction change restarts the ramp before this tick's move.
      if (req != state_q) begin
        spd_cur = spd_t'(STEP_MIN);
        cnt_cur = '0;
      end
      spd_d   = spd_cur;
      cnt_d   = cnt_cur;
      spd_ext = ye_t'(spd_cur);
      if (req != IDLE) begin
        if (req == UP) begin
          nxt = (y_ext < spd_ext) ? '0 : y_ext - spd_ext;
        end else begin
          nxt = y_ext + spd_ext;
          if (nxt > ye_t'(YMAX)) nxt = ye_t'(YMAX);
        end
        y_d = y_t'(nxt);
        if (cnt_cur == cnt_t'(ACCEL_TICKS - 1)) begin
          cnt_d = '0;
          if (spd_cur < spd_t'(STEP_MAX)) spd_d = spd_cur + spd_t'(1);
        end else begin
          cnt_d = cnt_cur + cnt_t'(1);
        end
      end
    end
  end

  assign paddle_y  = y_q;
  assign moving    = (state_q != IDLE);
  assign at_top    = (y_q == '0);
  assign at_bottom = (y_q == y_t'(YMAX));
endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: a tick-level behavioural model pushes expected
// outputs as each tick/center is driven; they are popped and compared after the edge.
module tb_paddle_ctrl;
  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, center = 1'b0;
  logic [9:0] paddle_y;
  logic       moving, at_top, at_bottom;

  int n_cmp = 0, n_err = 0;

  typedef struct {int y; int mv; int top; int bot;} exp_t;
  exp_t sb[$];

  int m_y = 208, m_st = 0, m_spd = 1, m_cnt = 0;
  bit [2:0] m_hu = '0, m_hd = '0;
  bit m_su = 0, m_sd = 0;

  paddle_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_up(btn_up), .btn_down(btn_down),
    .center(center), .paddle_y(paddle_y), .moving(moving), .at_top(at_top),
    .at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 208; m_st = 0; m_spd = 1; m_cnt = 0;
    m_hu = '0; m_hd = '0; m_su = 0; m_sd = 0;
  endtask

  task automatic model_tick();
    int req;
    req = (m_su && !m_sd) ? 1 : (m_sd && !m_su) ? 2 : 0;
    if (req != m_st) begin m_st = req; m_spd = 1; m_cnt = 0; end
    if (m_st == 1) m_y = (m_y < m_spd) ? 0 : m_y - m_spd;
    if (m_st == 2) m_y = (m_y + m_spd > 416) ? 416 : m_y + m_spd;
    if (m_st != 0) begin
      m_cnt++;
      if (m_cnt == 10) begin m_cnt = 0; if (m_spd < 8) m_spd++; end
    end
    m_hu = {m_hu[1:0], btn_up};
    m_hd = {m_hd[1:0], btn_down};
    if (m_hu == 3'b111) m_su = 1; else if (m_hu == 3'b000) m_su = 0;
    if (m_hd == 3'b111) m_sd = 1; else if (m_hd == 3'b000) m_sd = 0;
  endtask

  task automatic step(input bit t, input bit c);
    exp_t e;
    @(negedge clk);
    tick = t; center = c;
    if (c) begin m_y = 208; m_st = 0; m_spd = 1; m_cnt = 0; end
    else if (t) model_tick();
    if (t || c) sb.push_back('{m_y, int'(m_st != 0), int'(m_y == 0), int'(m_y == 416)});
    @(posedge clk); #1;
    tick = 1'b0; center = 1'b0;
    if (t || c) begin
      e = sb.pop_front();
      chk("y", int'(paddle_y), e.y);
      chk("moving", int'(moving), e.mv);
      chk("at_top", int'(at_top), e.top);
      chk("at_bot", int'(at_bottom), e.bot);
    end
  endtask

  // Three idle clocks give the synchroniser time to settle before each tick.
  task automatic tk();
    repeat (3) step(0, 0);
    step(1, 0);
  endtask

  initial begin
    int prev, saved;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_y", int'(paddle_y), 208);
    chk("rst_mv", int'(moving), 0);
    chk("rst_top", int'(at_top), 0);
    chk("rst_bot", int'(at_bottom), 0);
    @(negedge clk); rst = 1'b1;

    repeat (20) tk();
    chk("idle_y", int'(paddle_y), 208);

    btn_up = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tk();
      if (i == 3)  chk("up_t3", int'(paddle_y), 208);
      if (i == 4)  chk("up_t4", int'(paddle_y), 207);
      if (i == 13) chk("up_t13", int'(paddle_y), 198);
      if (i == 14) chk("up_t14", int'(paddle_y), 196);
    end
    while (m_spd != 3) tk();
    btn_up = 1'b0; btn_down = 1'b1;
    repeat (3) tk();
    saved = int'(paddle_y);
    tk();
    chk("rev_plus1", int'(paddle_y), saved + 1);

    for (int i = 0; i < 300; i++) begin
      prev = int'(paddle_y);
      tk();
      chk("dn_mono", int'(int'(paddle_y) >= prev), 1);
      chk("dn_max", int'(paddle_y <= 10'd416), 1);
    end
    chk("dn_end_y", int'(paddle_y), 416);
    chk("dn_end_bot", int'(at_bottom), 1);
    chk("dn_end_mv", int'(moving), 1);
    btn_down = 1'b0;
    repeat (4) tk();
    chk("rel_mv", int'(moving), 0);

    step(0, 1);
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (50) tk();
    chk("both_y", int'(paddle_y), 208);
    chk("both_mv", int'(moving), 0);

    btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) tk();
    for (int i = 0; i < 40; i++) begin
      btn_up = ~btn_up;
      tk();
    end
    chk("tog_y", int'(paddle_y), 208);
    btn_up = 1'b0;

    btn_down = 1'b1;
    while (m_spd != 4) tk();
    tk();
    step(0, 1);
    chk("ctr_y", int'(paddle_y), 208);
    chk("ctr_mv", int'(moving), 0);
    tk();
    chk("ctr_next", int'(paddle_y), 209);
    repeat (12) tk();

    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_y", int'(paddle_y), 208);
    chk("arst_mv", int'(moving), 0);
    chk("arst_top", int'(at_top), 0);
    chk("arst_bot", int'(at_bottom), 0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) tk();
    chk("post_rst_hold", int'(paddle_y), 208);
    tk();
    chk("post_rst_move", int'(paddle_y), 209);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
